// File: rtl/wb_shared_bus.sv
// Wishbone B3 shared-bus interconnect: NM masters, NS slaves, round-robin
// arbitration, address-field slave decode, unmapped-address and timeout bus errors.
module wb_shared_bus #(
    parameter int unsigned NM      = 2,
    parameter int unsigned NS      = 5,
    parameter int unsigned AW      = 32,
    parameter int unsigned DW      = 32,
    parameter int unsigned DEC_HI  = 31,
    parameter int unsigned DEC_LO  = 28,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NM*AW-1:0]     m_adr_i,
    input  logic [NM*DW-1:0]     m_dat_i,
    input  logic [NM*DW/8-1:0]   m_sel_i,
    input  logic [NM-1:0]        m_we_i,
    input  logic [NM-1:0]        m_cyc_i,
    input  logic [NM-1:0]        m_stb_i,
    output logic [NM*DW-1:0]     m_dat_o,
    output logic [NM-1:0]        m_ack_o,
    output logic [NM-1:0]        m_err_o,
    output logic [AW-1:0]        s_adr_o,
    output logic [DW-1:0]        s_dat_o,
    output logic [DW/8-1:0]      s_sel_o,
    output logic                 s_we_o,
    output logic [NS-1:0]        s_cyc_o,
    output logic [NS-1:0]        s_stb_o,
    input  logic [NS*DW-1:0]     s_dat_i,
    input  logic [NS-1:0]        s_ack_i,
    input  logic [NS-1:0]        s_err_i,
    output logic [NM-1:0]        grant_o
);

    localparam int unsigned SW = DW / 8;
    localparam int unsigned IW = DEC_HI - DEC_LO + 1;
    localparam int unsigned MW = (NM > 1) ? $clog2(NM) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } state_t;

    state_t         state;
    logic [MW-1:0]  ptr;
    logic [15:0]    to_cnt;
    logic           to_err;
    logic           unm_err;

    logic [AW-1:0]  g_adr;
    logic [DW-1:0]  g_dat;
    logic [SW-1:0]  g_sel;
    logic           g_we;
    logic           g_cyc;
    logic           g_stb;
    logic [MW-1:0]  gidx;
    logic [IW-1:0]  idx;
    logic           mapped;
    logic [DW-1:0]  sl_dat;
    logic           sl_ack;
    logic           sl_err;
    logic           m_err_c;
    logic           m_ack_c;
    logic [NM-1:0]  req_hi;
    logic [NM-1:0]  req_lo;
    logic [NM-1:0]  nxt_grant;

    // One-hot mux of the granted master's request; all zero when nobody owns the bus.
    always_comb begin
        g_adr = '0;
        g_dat = '0;
        g_sel = '0;
        g_we  = 1'b0;
        g_cyc = 1'b0;
        g_stb = 1'b0;
        gidx  = '0;
        for (int k = 0; k < NM; k++) begin
            if (grant_o[k]) begin
                g_adr = m_adr_i[k*AW +: AW];
                g_dat = m_dat_i[k*DW +: DW];
                g_sel = m_sel_i[k*SW +: SW];
                g_we  = m_we_i[k];
                g_cyc = m_cyc_i[k];
                g_stb = m_stb_i[k];
                gidx  = MW'(k);
            end
        end
    end

    assign idx    = g_adr[DEC_HI:DEC_LO];
    assign mapped = (32'(idx) < NS);

    // Slave decode and response select.
    always_comb begin
        s_cyc_o = '0;
        s_stb_o = '0;
        sl_dat  = '0;
        sl_ack  = 1'b0;
        sl_err  = 1'b0;
        for (int s = 0; s < NS; s++) begin
            if (mapped && (idx == IW'(s))) begin
                s_cyc_o[s] = g_cyc;
                s_stb_o[s] = g_stb;
                sl_dat     = s_dat_i[s*DW +: DW];
                sl_ack     = s_ack_i[s];
                sl_err     = s_err_i[s];
            end
        end
    end

    assign s_adr_o = g_adr;
    assign s_dat_o = g_dat;
    assign s_sel_o = g_sel;
    assign s_we_o  = g_we;

    // Errors from the bus itself override anything the slave says.
    assign m_err_c = to_err | unm_err | (sl_err & g_stb);
    assign m_ack_c = sl_ack & g_stb & ~m_err_c;

    always_comb begin
        m_dat_o = '0;
        m_ack_o = '0;
        m_err_o = '0;
        for (int k = 0; k < NM; k++) begin
            if (grant_o[k]) begin
                m_dat_o[k*DW +: DW] = sl_dat;
                m_ack_o[k]          = m_ack_c;
                m_err_o[k]          = m_err_c;
            end
        end
    end

    // Circular search from ptr: lowest requester at/after ptr, else lowest overall.
    always_comb begin
        req_hi = '0;
        req_lo = '0;
        for (int k = NM - 1; k >= 0; k--) begin
            if (m_cyc_i[k]) begin
                req_lo    = '0;
                req_lo[k] = 1'b1;
                if (MW'(k) >= ptr) begin
                    req_hi    = '0;
                    req_hi[k] = 1'b1;
                end
            end
        end
        nxt_grant = (req_hi != '0) ? req_hi : req_lo;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            grant_o <= '0;
            ptr     <= '0;
            to_cnt  <= '0;
            to_err  <= 1'b0;
            unm_err <= 1'b0;
        end else begin
            to_err  <= 1'b0;
            unm_err <= 1'b0;
            case (state)
                IDLE: begin
                    to_cnt <= '0;
                    if (m_cyc_i != '0) begin
                        grant_o <= nxt_grant;
                        state   <= OWN;
                    end
                end
                OWN: begin
                    if (!g_cyc) begin
                        grant_o <= '0;
                        state   <= IDLE;
                        to_cnt  <= '0;
                        ptr     <= (gidx == MW'(NM - 1)) ? '0 : gidx + MW'(1);
                    end else begin
                        // An error cycle completes the strobe; a held stb starts a new one.
                        unm_err <= g_stb & ~mapped & ~m_err_c;
                        if (!g_stb || sl_ack || m_err_c) begin
                            to_cnt <= '0;
                        end else if (to_cnt == 16'(TIMEOUT - 1)) begin
                            to_cnt <= '0;
                            to_err <= 1'b1;
                        end else begin
                            to_cnt <= to_cnt + 16'd1;
                        end
                    end
                end
                default: begin
                    state   <= IDLE;
                    grant_o <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_shared_bus.sv
// Self-checking bench for wb_shared_bus: slave responses scripted per scenario,
// master-side responses checked against a scoreboard of expected ack/err events.
module tb_wb_shared_bus;

    localparam int unsigned NM = 2;
    localparam int unsigned NS = 5;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;

    logic                clk;
    logic                rst;
    logic [NM*AW-1:0]    m_adr;
    logic [NM*DW-1:0]    m_dat;
    logic [NM*DW/8-1:0]  m_sel;
    logic [NM-1:0]       m_we;
    logic [NM-1:0]       m_cyc;
    logic [NM-1:0]       m_stb;
    logic [NM*DW-1:0]    m_dat_o;
    logic [NM-1:0]       m_ack_o;
    logic [NM-1:0]       m_err_o;
    logic [AW-1:0]       s_adr_o;
    logic [DW-1:0]       s_dat_o;
    logic [DW/8-1:0]     s_sel_o;
    logic                s_we_o;
    logic [NS-1:0]       s_cyc_o;
    logic [NS-1:0]       s_stb_o;
    logic [NS*DW-1:0]    s_dat;
    logic [NS-1:0]       s_ack;
    logic [NS-1:0]       s_err;
    logic [NM-1:0]       grant_o;

    wb_shared_bus #(
        .NM(NM), .NS(NS), .AW(AW), .DW(DW),
        .DEC_HI(31), .DEC_LO(28), .TIMEOUT(8)
    ) dut (
        .clk(clk), .rst(rst),
        .m_adr_i(m_adr), .m_dat_i(m_dat), .m_sel_i(m_sel), .m_we_i(m_we),
        .m_cyc_i(m_cyc), .m_stb_i(m_stb),
        .m_dat_o(m_dat_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_we_o(s_we_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o),
        .s_dat_i(s_dat), .s_ack_i(s_ack), .s_err_i(s_err),
        .grant_o(grant_o)
    );

    typedef struct {
        logic [1:0]  mask;
        logic        err;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc_n    = 0;
    int   t0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc_n <= cyc_n + 1;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_m(input int k, input logic cyc, input logic stb, input logic [31:0] adr);
        m_cyc[k]            = cyc;
        m_stb[k]            = stb;
        m_adr[k*AW +: AW]   = adr;
        m_dat[k*DW +: DW]   = adr ^ 32'h5a5a_5a5a;
        m_sel[k*4 +: 4]     = 4'hf;
        m_we[k]             = 1'b0;
    endtask

    task automatic set_s(input int s, input logic ack, input logic err, input logic [31:0] d);
        s_ack[s]          = ack;
        s_err[s]          = err;
        s_dat[s*DW +: DW] = d;
    endtask

    task automatic push(input logic [1:0] mask, input logic err, input logic [31:0] d, input int c);
        exp_t e;
        e.mask = mask;
        e.err  = err;
        e.data = d;
        e.cyc  = c;
        sb.push_back(e);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2 rst = 1'b0;
        step(2);
        rst = 1'b1;
    endtask

    // Every ack/err seen by a master must match the oldest expected response.
    always @(negedge clk) begin
        if ((m_ack_o | m_err_o) != '0) begin
            if (sb.size() == 0) begin
                check("spurious_resp", {m_ack_o, m_err_o}, 64'd0);
            end else begin
                mon_e = sb.pop_front();
                check("resp_master", m_ack_o | m_err_o, mon_e.mask);
                check("resp_err", |m_err_o, mon_e.err);
                check("resp_ack", |m_ack_o, !mon_e.err);
                check("resp_cycle", cyc_n, mon_e.cyc);
                if (!mon_e.err)
                    check("resp_data", m_dat_o,
                          mon_e.mask[1] ? {mon_e.data, 32'h0} : {32'h0, mon_e.data});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        rst   = 1'b1;
        m_adr = '0; m_dat = '0; m_sel = '0; m_we = '0; m_cyc = '0; m_stb = '0;
        s_dat = '0; s_ack = '0; s_err = '0;
        set_m(0, 1'b1, 1'b1, 32'h1000_0000);
        set_m(1, 1'b1, 1'b1, 32'h2000_0000);
        #1 rst = 1'b0;
        #1;
        check("rst_grant", grant_o, 0);
        check("rst_s_cyc", s_cyc_o, 0);
        check("rst_s_stb", s_stb_o, 0);
        check("rst_s_adr", s_adr_o, 0);
        check("rst_m_resp", {m_ack_o, m_err_o, m_dat_o}, 0);
        set_m(0, 1'b0, 1'b0, 32'h0);
        set_m(1, 1'b0, 1'b0, 32'h0);
        step(2);
        rst = 1'b1;
        step(1);

        // Single read: M0 -> S1, ack two cycles after grant.
        set_m(0, 1'b1, 1'b1, 32'h1000_0004);
        #1 check("rd_grant_pre", grant_o, 0);
        step(1);
        check("rd_grant", grant_o, 2'b01);
        check("rd_s_stb", s_stb_o, 5'b00010);
        check("rd_s_cyc", s_cyc_o, 5'b00010);
        check("rd_s_adr", s_adr_o, 32'h1000_0004);
        check("rd_s_dat", s_dat_o, 32'h1000_0004 ^ 32'h5a5a_5a5a);
        check("rd_s_sel_we", {s_sel_o, s_we_o}, 5'b11110);
        step(2);
        set_s(1, 1'b1, 1'b0, 32'hDEAD_BEEF);
        push(2'b01, 1'b0, 32'hDEAD_BEEF, cyc_n);
        step(1);
        set_s(1, 1'b0, 1'b0, 32'h0);
        set_m(0, 1'b0, 1'b0, 32'h0);
        step(1);
        check("rd_release", grant_o, 0);

        // Contention right after reset: M0, then M1 after an idle cycle, then M0 again.
        do_reset();
        set_m(0, 1'b1, 1'b0, 32'h0);
        set_m(1, 1'b1, 1'b0, 32'h0);
        step(1);
        check("arb_first", grant_o, 2'b01);
        step(2);
        check("arb_hold", grant_o, 2'b01);
        set_m(0, 1'b0, 1'b0, 32'h0);
        step(1);
        check("arb_idle", grant_o, 2'b00);
        step(1);
        check("arb_second", grant_o, 2'b10);
        set_m(1, 1'b0, 1'b0, 32'h0);
        step(1);
        check("arb_idle2", grant_o, 2'b00);
        set_m(0, 1'b1, 1'b0, 32'h0);
        set_m(1, 1'b1, 1'b0, 32'h0);
        step(1);
        check("arb_wrap", grant_o, 2'b01);
        set_m(0, 1'b0, 1'b0, 32'h0);
        set_m(1, 1'b0, 1'b0, 32'h0);
        step(2);

        // Unmapped: M1 -> 0x7000_0000, err one cycle after stb; a new strobe errors again.
        set_m(1, 1'b1, 1'b1, 32'h7000_0000);
        step(1);
        check("unm_grant", grant_o, 2'b10);
        check("unm_no_stb", {s_cyc_o, s_stb_o}, 0);
        push(2'b10, 1'b1, 32'h0, cyc_n + 1);
        step(1);
        check("unm_err", m_err_o, 2'b10);
        m_stb[1] = 1'b0;
        step(1);
        check("unm_pulse_end", m_err_o, 2'b00);
        m_stb[1] = 1'b1;
        push(2'b10, 1'b1, 32'h0, cyc_n + 1);
        step(1);
        check("unm_reissue", m_err_o, 2'b10);
        set_m(1, 1'b0, 1'b0, 32'h0);
        step(2);

        // Timeout: S2 silent, err 8 cycles after stb, late ack in that cycle dropped.
        set_m(0, 1'b1, 1'b1, 32'h2000_0000);
        step(1);
        t0 = cyc_n;
        check("to_s_stb", s_stb_o, 5'b00100);
        push(2'b01, 1'b1, 32'h0, t0 + 8);
        step(7);
        check("to_quiet", {m_ack_o, m_err_o}, 0);
        step(1);
        set_s(2, 1'b1, 1'b0, 32'h1234_5678);
        #1;
        check("to_err", m_err_o, 2'b01);
        check("to_ack_suppr", m_ack_o, 2'b00);
        step(1);
        set_s(2, 1'b0, 1'b0, 32'h0);
        set_m(0, 1'b0, 1'b0, 32'h0);
        step(2);

        // Reset while M0 waits on S3.
        set_m(0, 1'b1, 1'b1, 32'h3000_0000);
        step(1);
        check("rm_s_stb", s_stb_o, 5'b01000);
        #2 rst = 1'b0;
        #1;
        check("rm_grant", grant_o, 0);
        check("rm_s_cyc_stb", {s_cyc_o, s_stb_o}, 0);
        check("rm_m_resp", {m_ack_o, m_err_o}, 0);
        step(1);
        rst = 1'b1;
        step(1);
        check("rm_regrant", grant_o, 2'b01);
        set_m(0, 1'b0, 1'b0, 32'h0);
        step(2);

        // Burst: M0 strobes S0 then S2 within one cyc while M1 waits.
        set_m(0, 1'b1, 1'b1, 32'h0000_0000);
        step(1);
        check("bu_grant", grant_o, 2'b01);
        check("bu_s0", s_stb_o, 5'b00001);
        set_s(0, 1'b1, 1'b0, 32'h1111_1111);
        push(2'b01, 1'b0, 32'h1111_1111, cyc_n);
        set_m(1, 1'b1, 1'b1, 32'h1000_0000);
        step(1);
        set_s(0, 1'b0, 1'b0, 32'h0);
        set_m(0, 1'b1, 1'b1, 32'h2000_0000);
        #1;
        check("bu_s2", s_stb_o, 5'b00100);
        check("bu_hold", grant_o, 2'b01);
        step(1);
        set_s(2, 1'b1, 1'b0, 32'h2222_2222);
        push(2'b01, 1'b0, 32'h2222_2222, cyc_n);
        step(1);
        set_s(2, 1'b0, 1'b0, 32'h0);
        set_m(0, 1'b0, 1'b0, 32'h0);
        check("bu_hold2", grant_o, 2'b01);
        step(1);
        check("bu_idle", grant_o, 2'b00);
        step(1);
        check("bu_m1", grant_o, 2'b10);
        set_m(1, 1'b0, 1'b0, 32'h0);
        step(2);

        // Slave ack and err together: master sees err only.
        set_m(1, 1'b1, 1'b1, 32'h4000_0000);
        step(1);
        check("ae_s4", s_stb_o, 5'b10000);
        set_s(4, 1'b1, 1'b1, 32'h0BAD_0BAD);
        push(2'b10, 1'b1, 32'h0, cyc_n);
        #1 check("ae_no_ack", m_ack_o, 2'b00);
        step(1);
        set_s(4, 1'b0, 1'b0, 32'h0);
        set_m(1, 1'b0, 1'b0, 32'h0);
        step(2);

        // Master drops cyc in the ack cycle: ack still forwarded, then bus released.
        set_m(0, 1'b1, 1'b1, 32'h1000_0008);
        step(1);
        set_s(1, 1'b1, 1'b0, 32'hCAFE_F00D);
        m_cyc[0] = 1'b0;
        push(2'b01, 1'b0, 32'hCAFE_F00D, cyc_n);
        step(1);
        set_s(1, 1'b0, 1'b0, 32'h0);
        set_m(0, 1'b0, 1'b0, 32'h0);
        check("cd_release", grant_o, 2'b00);
        step(3);

        check("sb_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
